// File: rtl/uart_pkg.sv
// Shared UART constants, frame-time derivation and the transmit pacing state type.
package uart_pkg;

  localparam int SYS_CLK_HZ     = 27_000_000;
  localparam int BAUD           = 115200;
  localparam int BITS_PER_FRAME = 10;

  // Cycles per frame rounded up to the next multiple of 100 for margin (2344 -> 2400).
  function automatic int frame_cycles_with_margin(input int clk_hz, input int baud, input int bits);
    int raw;
    raw = (clk_hz * bits + baud - 1) / baud;
    return ((raw + 99) / 100) * 100;
  endfunction

  localparam int FRAME_CYCLES_DEFAULT = frame_cycles_with_margin(SYS_CLK_HZ, BAUD, BITS_PER_FRAME);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count; no bypass, head is read combinationally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == FULL_COUNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffers bytes for a busy-flag-less UART transmitter and launches one byte per frame time,
// gated by the host's synchronised clear-to-send line.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int FRAME_CYCLES = FRAME_CYCLES_DEFAULT
) (
  input  logic                   sys_clk,
  input  logic                   rst,
  input  logic [7:0]             wr_data,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic                   rts_n,
  output logic [7:0]             tx_par,
  output logic                   tx_start,
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy
);

  localparam int FW = $clog2(FRAME_CYCLES);
  localparam logic [FW-1:0] FRAME_LOAD = FW'(FRAME_CYCLES - 1);
  localparam logic [FW-1:0] FRAME_ONE  = FW'(1);

  tx_state_e   state_q, state_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [7:0]  tx_par_q, tx_par_d;
  logic        rts_meta_q, rts_s_q;
  logic [7:0]  head_data;
  logic        fifo_full, fifo_empty, launch;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (sys_clk),
    .rst_i   (rst),
    .push_i  (wr_valid),
    .pop_i   (launch),
    .wdata_i (wr_data),
    .rdata_o (head_data),
    .count_o (count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign wr_ready = !fifo_full;
  assign launch   = (state_q == IDLE) && !fifo_empty && !rts_s_q;
  assign tx_par   = tx_par_q;

  // Synchroniser resets to "not clear" so nothing launches before the host line is seen.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      rts_meta_q <= 1'b1;
      rts_s_q    <= 1'b1;
    end else begin
      rts_meta_q <= rts_n;
      rts_s_q    <= rts_meta_q;
    end
  end

  // Reset lands in WAIT so a frame already in the transmitter is never overrun.
  always_ff @(posedge sys_clk) begin
    if (rst) state_q <= WAIT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (launch) state_d = START;
      START:   state_d = WAIT;
      WAIT:    if (frame_q == '0) state_d = IDLE;
      default: state_d = WAIT;
    endcase
  end

  always_comb begin
    tx_start = (state_q == START);
    busy     = (state_q != IDLE);
  end

  // Counting through START as well keeps launch-to-launch spacing at FRAME_CYCLES + 1.
  always_comb begin
    frame_d  = frame_q;
    tx_par_d = tx_par_q;
    if (launch) begin
      frame_d  = FRAME_LOAD;
      tx_par_d = head_data;
    end else if ((state_q != IDLE) && (frame_q != '0)) begin
      frame_d = frame_q - FRAME_ONE;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      frame_q  <= FRAME_LOAD;
      tx_par_q <= 8'h00;
    end else begin
      frame_q  <= frame_d;
      tx_par_q <= tx_par_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo with a short frame time and a byte-order model.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int F     = 12;

  logic       sysClk = 1'b0;
  logic       rst;
  logic [7:0] wrData;
  logic       wrValid;
  logic       wrReady;
  logic       rtsN;
  logic [7:0] txPar;
  logic       txStart;
  logic [4:0] count;
  logic       busy;

  int checkCount = 0;
  int passCount  = 0;
  logic [7:0] model[$];

  uart_tx_fifo #(
    .DEPTH        (DEPTH),
    .FRAME_CYCLES (F)
  ) dut (
    .sys_clk  (sysClk),
    .rst      (rst),
    .wr_data  (wrData),
    .wr_valid (wrValid),
    .wr_ready (wrReady),
    .rts_n    (rtsN),
    .tx_par   (txPar),
    .tx_start (txStart),
    .count    (count),
    .busy     (busy)
  );

  always #5 sysClk = ~sysClk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  task automatic tick();
    @(posedge sysClk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] data);
    wrData  = data;
    wrValid = 1'b1;
    tick();
    wrValid = 1'b0;
    model.push_back(data);
  endtask

  task automatic waitPulse(input int maxCycles, output int n);
    n = -1;
    for (int i = 1; i <= maxCycles; i++) begin
      tick();
      if (txStart) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic waitIdle(input int maxCycles, output int n);
    n = -1;
    for (int i = 1; i <= maxCycles; i++) begin
      tick();
      if (!busy) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic checkLaunch(input string tag, input int n, input int expectedGap);
    logic [7:0] expByte;
    expByte = (model.size() != 0) ? model.pop_front() : 8'hXX;
    checkOutput({tag, "_gap"}, 32'(n), 32'(expectedGap));
    checkOutput({tag, "_byte"}, 32'(txPar), 32'(expByte));
  endtask

  initial begin
    int n;
    int pulses;

    rst = 1'b1; wrValid = 1'b0; wrData = 8'h00; rtsN = 1'b0;
    tick();
    checkOutput("rst_wrReady", 32'(wrReady), 32'd1);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd1);
    checkOutput("rst_txStart", 32'(txStart), 32'd0);
    checkOutput("rst_txPar", 32'(txPar), 32'd0);
    tick();
    rst = 1'b0;
    waitIdle(4 * F, n);
    checkOutput("rst_guardLen", 32'(n), 32'(F));

    // Single byte through an idle block.
    applyStimulus(8'h55);
    checkOutput("t1_countAfterAccept", 32'(count), 32'd1);
    checkOutput("t1_noEarlyStart", 32'(txStart), 32'd0);
    tick();
    checkOutput("t1_txStart", 32'(txStart), 32'd1);
    checkOutput("t1_txPar", 32'(txPar), 32'h55);
    checkOutput("t1_countAfterPop", 32'(count), 32'd0);
    void'(model.pop_front());
    tick();
    checkOutput("t1_singlePulse", 32'(txStart), 32'd0);
    waitIdle(4 * F, n);
    checkOutput("t1_idleDelay", 32'(n), 32'(F - 1));

    // Fill while blocked, then drain in order.
    rtsN = 1'b1;
    tick(); tick(); tick();
    for (int i = 1; i <= DEPTH; i++) applyStimulus(8'(i));
    checkOutput("t2_fullWrReady", 32'(wrReady), 32'd0);
    checkOutput("t2_fullCount", 32'(count), 32'd16);
    wrData = 8'hEE; wrValid = 1'b1;
    tick();
    wrValid = 1'b0;
    checkOutput("t2_overflowCount", 32'(count), 32'd16);
    rtsN = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      waitPulse(3 * F, n);
      checkLaunch($sformatf("t2_launch%0d", k), n, (k == 0) ? 3 : F + 1);
      if (k == 0) checkOutput("t2_wrReadyAfterPop", 32'(wrReady), 32'd1);
    end
    waitIdle(4 * F, n);
    checkOutput("t2_drainedCount", 32'(count), 32'd0);

    // Flow control raised during byte 3's frame.
    rtsN = 1'b1;
    tick(); tick(); tick();
    for (int i = 0; i < 8; i++) applyStimulus(8'hA0 + 8'(i));
    rtsN = 1'b0;
    for (int k = 0; k < 3; k++) begin
      waitPulse(3 * F, n);
      checkLaunch($sformatf("t3_launch%0d", k), n, (k == 0) ? 3 : F + 1);
    end
    tick(); tick();
    rtsN = 1'b1;
    pulses = 0;
    for (int i = 0; i < 2 * F; i++) begin
      tick();
      if (txStart) pulses++;
    end
    checkOutput("t3_blockedPulses", 32'(pulses), 32'd0);
    checkOutput("t3_blockedBusy", 32'(busy), 32'd0);
    checkOutput("t3_blockedCount", 32'(count), 32'd5);
    rtsN = 1'b0;
    for (int k = 3; k < 8; k++) begin
      waitPulse(3 * F, n);
      checkLaunch($sformatf("t3_launch%0d", k), n, (k == 3) ? 3 : F + 1);
    end
    waitIdle(4 * F, n);

    // Push on the same edge as each pop while five bytes are held; pointers wrap here.
    rtsN = 1'b1;
    tick(); tick(); tick();
    for (int i = 0; i < 5; i++) applyStimulus(8'hC0 + 8'(i));
    checkOutput("t4_preCount", 32'(count), 32'd5);
    rtsN = 1'b0;
    waitPulse(3 * F, n);
    checkLaunch("t4_first", n, 3);
    applyStimulus(8'hC5);
    checkOutput("t4_refillCount", 32'(count), 32'd5);
    for (int j = 0; j < 5; j++) begin
      waitIdle(4 * F, n);
      wrData = 8'hD0 + 8'(j); wrValid = 1'b1;
      tick();
      wrValid = 1'b0;
      checkOutput($sformatf("t4_pushPopStart%0d", j), 32'(txStart), 32'd1);
      checkOutput($sformatf("t4_pushPopCount%0d", j), 32'(count), 32'd5);
      checkLaunch($sformatf("t4_pushPop%0d", j), 0, 0);
      model.push_back(8'hD0 + 8'(j));
    end
    for (int k = 0; k < 5; k++) begin
      waitPulse(3 * F, n);
      checkLaunch($sformatf("t4_drain%0d", k), n, F + 1);
    end
    waitIdle(4 * F, n);

    // Reset mid-frame with bytes queued.
    for (int i = 0; i < 5; i++) begin
      wrData = 8'hE0 + 8'(i); wrValid = 1'b1;
      tick();
    end
    wrValid = 1'b0;
    checkOutput("t5_queuedCount", 32'(count), 32'd4);
    checkOutput("t5_queuedBusy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model.delete();
    checkOutput("t5_rstCount", 32'(count), 32'd0);
    checkOutput("t5_rstWrReady", 32'(wrReady), 32'd1);
    checkOutput("t5_rstTxPar", 32'(txPar), 32'd0);
    checkOutput("t5_rstBusy", 32'(busy), 32'd1);
    applyStimulus(8'h77);
    waitPulse(4 * F, n);
    checkLaunch("t5_guardedLaunch", n, F);
    waitIdle(4 * F, n);
    checkOutput("t5_finalBusy", 32'(busy), 32'd0);
    checkOutput("t5_finalCount", 32'(count), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
